// File: rtl/systolic_drain.sv
// De-skews the staggered column results leaving the bottom of a systolic array
// into whole rows and buffers them in a FIFO for a ready/valid consumer.
module systolic_drain #(
   parameter int N         = 4,
   parameter int ACC_WIDTH = 32,
   parameter int DEPTH     = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [N*ACC_WIDTH-1:0]   y_in,
   input  logic [N-1:0]             y_valid,
   input  logic                     err_clr,
   output logic [N*ACC_WIDTH-1:0]   out_data,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     almost_full,
   output logic                     overflow,
   output logic                     skew_err
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int RW = N * ACC_WIDTH;

   localparam logic [CW-1:0] FULL_LEVEL = CW'(DEPTH);
   localparam logic [CW-1:0] AF_LEVEL   = CW'(DEPTH - N);

   // Row as seen after the per-column delay lines.
   logic [RW-1:0] al_data;
   logic [N-1:0]  al_valid;

   // ------------------------------------------------------------------
   // De-skew: column j waits N-1-j cycles so every column of a row lines
   // up with the last column. The array cannot stall, so these always shift.
   // ------------------------------------------------------------------
   for (genvar j = 0; j < N; j++) begin : g_col
      if (j == N - 1) begin : g_pass
         assign al_data[j*ACC_WIDTH +: ACC_WIDTH] = y_in[j*ACC_WIDTH +: ACC_WIDTH];
         assign al_valid[j]                       = y_valid[j];
      end else begin : g_dly
         localparam int L = N - 1 - j;

         logic [ACC_WIDTH-1:0] data_q [L];
         logic [ACC_WIDTH-1:0] data_d [L];
         logic [L-1:0]         vld_q;
         logic [L-1:0]         vld_d;

         always_comb begin
            data_d[0] = y_in[j*ACC_WIDTH +: ACC_WIDTH];
            vld_d[0]  = y_valid[j];
            for (int k = 1; k < L; k++) begin
               data_d[k] = data_q[k-1];
               vld_d[k]  = vld_q[k-1];
            end
         end

         // NOTE: state is updated only with non-blocking assignments so every
         // stage samples its neighbour's pre-edge value, whatever the block order.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               for (int k = 0; k < L; k++) data_q[k] <= '0;
               vld_q <= '0;
            end else begin
               data_q <= data_d;
               vld_q  <= vld_d;
            end
         end

         assign al_data[j*ACC_WIDTH +: ACC_WIDTH] = data_q[L-1];
         assign al_valid[j]                       = vld_q[L-1];
      end
   end

   // ------------------------------------------------------------------
   // Row classification and FIFO control
   // ------------------------------------------------------------------
   logic [RW-1:0]  mem_q [DEPTH];
   logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]  count_q, count_d;
   logic           overflow_q, overflow_d;
   logic           skew_err_q, skew_err_d;

   logic row_ok;
   logic row_mixed;
   logic full;
   logic pop;
   logic push;
   logic drop;

   assign row_ok    = &al_valid;
   assign row_mixed = (|al_valid) && !row_ok;
   assign full      = (count_q == FULL_LEVEL);
   assign pop       = (count_q != '0) && out_ready;
   // A pop frees the slot on the same edge, so a full FIFO still accepts.
   assign push      = row_ok && (!full || pop);
   assign drop      = row_ok && full && !pop;

   // NOTE: every output of this block is given a default before any branch,
   // so no path leaves a signal unassigned and no latch is inferred.
   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      overflow_d = overflow_q;
      skew_err_d = skew_err_q;

      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);

      case ({push, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase

      // A fresh error in the clearing cycle takes priority over the clear.
      if (drop)         overflow_d = 1'b1;
      else if (err_clr) overflow_d = 1'b0;

      if (row_mixed)    skew_err_d = 1'b1;
      else if (err_clr) skew_err_d = 1'b0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
         skew_err_q <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
         skew_err_q <= skew_err_d;
      end
   end

   // NOTE: the row storage is reset as well, because out_data is read straight
   // from the head slot and must come out of reset as zero.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else if (push) begin
         mem_q[wr_ptr_q] <= al_data;
      end
   end

   assign out_data    = mem_q[rd_ptr_q];
   assign out_valid   = (count_q != '0);
   assign count       = count_q;
   assign almost_full = (count_q >= AF_LEVEL);
   assign overflow    = overflow_q;
   assign skew_err    = skew_err_q;

endmodule

// File: tb/tb_systolic_drain.sv
// Bench for systolic_drain: skewed row driver, expected-row queue filled at
// issue time, and a negedge monitor that pops and compares on every transfer.
module tb_systolic_drain;

   localparam int N     = 4;
   localparam int W     = 32;
   localparam int DEPTH = 8;
   localparam int CW    = $clog2(DEPTH) + 1;
   localparam int RW    = N * W;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [RW-1:0] y_in;
   logic [N-1:0]  y_valid;
   logic          err_clr;
   logic [RW-1:0] out_data;
   logic          out_valid;
   logic          out_ready;
   logic [CW-1:0] count;
   logic          almost_full;
   logic          overflow;
   logic          skew_err;

   always #5 clk = ~clk;

   systolic_drain #(.N(N), .ACC_WIDTH(W), .DEPTH(DEPTH)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .y_in        (y_in),
      .y_valid     (y_valid),
      .err_clr     (err_clr),
      .out_data    (out_data),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .count       (count),
      .almost_full (almost_full),
      .overflow    (overflow),
      .skew_err    (skew_err)
   );

   int n_vec = 0;
   int n_err = 0;

   logic [RW-1:0] sb [$];

   // Rows issued in the last N cycles; column j is fed from entry j.
   logic          h_v [N];
   logic [N-1:0]  h_m [N];
   logic [RW-1:0] h_d [N];

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [RW-1:0] mk_row(input int r);
      logic [RW-1:0] row;
      for (int j = 0; j < N; j++) row[j*W +: W] = 16 * r + j;
      return row;
   endfunction

   task automatic clear_hist();
      for (int i = 0; i < N; i++) begin
         h_v[i] = 1'b0;
         h_m[i] = '0;
         h_d[i] = '0;
      end
      y_valid = '0;
      y_in    = '0;
   endtask

   // Drives one cycle of skewed input; entered and left at posedge+1.
   task automatic cycle(input logic issue, input logic store, input logic [RW-1:0] row,
                        input logic [N-1:0] mask);
      for (int i = N - 1; i > 0; i--) begin
         h_v[i] = h_v[i-1];
         h_m[i] = h_m[i-1];
         h_d[i] = h_d[i-1];
      end
      h_v[0] = issue;
      h_m[0] = mask;
      h_d[0] = row;
      if (issue && store) sb.push_back(row);
      for (int j = 0; j < N; j++) begin
         y_valid[j]       = h_v[j] & h_m[j][j];
         y_in[j*W +: W]   = h_d[j][j*W +: W];
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) cycle(1'b0, 1'b0, '0, '0);
   endtask

   // Monitor: compares every accepted row against the queue and checks the
   // head stays put while the consumer is stalling.
   logic          hold = 1'b0;
   logic [RW-1:0] hold_data;
   logic [RW-1:0] exp_row;

   always @(negedge clk) begin
      if (!rst_n) begin
         hold = 1'b0;
      end else begin
         if (hold) begin
            check("hold_valid", 128'(out_valid), 128'(1));
            check("hold_data", out_data, hold_data);
         end
         if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
               n_vec++;
               n_err++;
               $display("FAIL unexpected_row: got %0h expected none", out_data);
            end else begin
               exp_row = sb.pop_front();
               check("row_data", out_data, exp_row);
            end
         end
         hold      = out_valid && !out_ready;
         hold_data = out_data;
      end
   end

   logic [RW-1:0] rnd_row;

   initial begin
      rst_n     = 1'b0;
      err_clr   = 1'b0;
      out_ready = 1'b0;
      clear_hist();
      repeat (2) @(posedge clk);
      #1;
      check("rst_out_valid", 128'(out_valid), 128'(0));
      check("rst_count", 128'(count), 128'(0));
      check("rst_almost_full", 128'(almost_full), 128'(0));
      check("rst_overflow", 128'(overflow), 128'(0));
      check("rst_skew_err", 128'(skew_err), 128'(0));
      check("rst_out_data", out_data, 128'(0));
      rst_n = 1'b1;

      // Three back-to-back rows, consumer always ready, latency N.
      out_ready = 1'b1;
      cycle(1'b1, 1'b1, mk_row(1), '1);
      cycle(1'b1, 1'b1, mk_row(2), '1);
      cycle(1'b1, 1'b1, mk_row(3), '1);
      check("lat_not_yet", 128'(out_valid), 128'(0));
      idle(1);
      check("lat_first_valid", 128'(out_valid), 128'(1));
      check("lat_first_data", out_data, mk_row(1));
      idle(4);
      check("t1_count", 128'(count), 128'(0));
      check("t1_all_seen", 128'(sb.size()), 128'(0));

      // Fill with the consumer stalled; the ninth row overflows.
      out_ready = 1'b0;
      for (int i = 1; i <= 9; i++) begin
         cycle(1'b1, (i <= 8) ? 1'b1 : 1'b0, mk_row(32 + i), '1);
         if (i == 6) begin
            check("af_count3", 128'(count), 128'(3));
            check("af_low_at_3", 128'(almost_full), 128'(0));
         end
         if (i == 7) begin
            check("af_count4", 128'(count), 128'(4));
            check("af_high_at_4", 128'(almost_full), 128'(1));
         end
      end
      idle(4);
      check("full_count", 128'(count), 128'(8));
      check("full_almost_full", 128'(almost_full), 128'(1));
      check("full_overflow", 128'(overflow), 128'(1));
      check("full_skew_err", 128'(skew_err), 128'(0));

      err_clr = 1'b1;
      idle(1);
      err_clr = 1'b0;
      check("ovf_cleared", 128'(overflow), 128'(0));

      // Write and pop on the same edge while full.
      cycle(1'b1, 1'b1, mk_row(50), '1);
      idle(2);
      out_ready = 1'b1;
      idle(1);
      out_ready = 1'b0;
      check("full_wr_pop_count", 128'(count), 128'(8));
      check("full_wr_pop_ovf", 128'(overflow), 128'(0));
      out_ready = 1'b1;
      idle(12);
      check("t2_count", 128'(count), 128'(0));
      check("t2_all_seen", 128'(sb.size()), 128'(0));

      // Column 2 missing for one row: flagged and discarded.
      cycle(1'b1, 1'b0, mk_row(60), 4'b1011);
      cycle(1'b1, 1'b1, mk_row(61), '1);
      idle(2);
      check("skew_set", 128'(skew_err), 128'(1));
      check("skew_no_ovf", 128'(overflow), 128'(0));
      idle(4);
      check("skew_count", 128'(count), 128'(0));
      err_clr = 1'b1;
      idle(1);
      err_clr = 1'b0;
      check("skew_cleared", 128'(skew_err), 128'(0));

      // Clear coinciding with a new skew error: the error wins.
      cycle(1'b1, 1'b0, mk_row(62), 4'b1101);
      idle(2);
      err_clr = 1'b1;
      idle(1);
      err_clr = 1'b0;
      check("clr_vs_new_err", 128'(skew_err), 128'(1));
      err_clr = 1'b1;
      idle(1);
      err_clr = 1'b0;
      check("skew_cleared2", 128'(skew_err), 128'(0));

      // Reset while a row is half way through the delay lines.
      cycle(1'b1, 1'b0, mk_row(70), '1);
      idle(1);
      #1 rst_n = 1'b0;
      clear_hist();
      #2 rst_n = 1'b1;
      idle(6);
      check("mid_rst_valid", 128'(out_valid), 128'(0));
      check("mid_rst_count", 128'(count), 128'(0));
      check("mid_rst_skew", 128'(skew_err), 128'(0));
      check("mid_rst_ovf", 128'(overflow), 128'(0));

      // Random traffic; upstream honours almost_full so nothing may be lost.
      for (int c = 0; c < 10000; c++) begin
         out_ready = 1'($urandom_range(0, 1));
         if (!almost_full && ($urandom_range(0, 1) != 0)) begin
            for (int j = 0; j < N; j++) rnd_row[j*W +: W] = $urandom();
            cycle(1'b1, 1'b1, rnd_row, '1);
         end else begin
            idle(1);
         end
      end
      out_ready = 1'b1;
      idle(20);
      check("rnd_count", 128'(count), 128'(0));
      check("rnd_overflow", 128'(overflow), 128'(0));
      check("rnd_skew_err", 128'(skew_err), 128'(0));
      check("rnd_all_seen", 128'(sb.size()), 128'(0));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/systolic_drain.md
SYSTOLIC_DRAIN -- requirements
Module: systolic_drain

Interface
REQ-001 Parameter N, default 4: systolic array column count.
REQ-002 Parameter ACC_WIDTH, default 32: per-column partial-sum width.
REQ-003 Parameter DEPTH, default 8: output FIFO depth in aligned rows; power of two, DEPTH >= N+1.
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 y_in  input  N*ACC_WIDTH  skewed column results from array bottom; column j at bits [j*ACC_WIDTH +: ACC_WIDTH].
REQ-007 y_valid  input  N  per-column valid; column j of a row arrives j cycles after column 0.
REQ-008 err_clr  input  1  synchronous clear of sticky error flags.
REQ-009 out_data  output  N*ACC_WIDTH  aligned row, same column packing as y_in.
REQ-010 out_valid  output  1  FIFO head valid.
REQ-011 out_ready  input  1  downstream accept; transfer when out_valid && out_ready.
REQ-012 count  output  $clog2(DEPTH)+1  FIFO occupancy.
REQ-013 almost_full  output  1  count >= DEPTH-N; upstream stops issuing rows.
REQ-014 overflow  output  1  sticky: aligned row dropped, FIFO full.
REQ-015 skew_err  output  1  sticky: aligned valids not all equal.

Function
REQ-016 Column j passes through a delay line of N-1-j registers (data and valid); column N-1 undelayed.
REQ-017 Delay lines free-run every cycle; no stall (array cannot stall).
REQ-018 Aligned valid vector all ones -> row is a write candidate that cycle.
REQ-019 Row with column 0 valid at cycle t is written at end of cycle t+N-1; out_valid high at t+N if FIFO was empty (latency N, no bypass).
REQ-020 Aligned valid vector mixed (neither all ones nor all zeros) -> skew_err set next cycle, row discarded, no write.
REQ-021 Write when count==DEPTH and no pop in same cycle -> row dropped, overflow set next cycle, FIFO unchanged.
REQ-022 Write and pop in same cycle when full -> both succeed, count stays DEPTH, no overflow.
REQ-023 Write and pop in same cycle otherwise -> count unchanged.
REQ-024 Empty FIFO: out_valid low; out_ready ignored; out_data holds last value, no meaning.
REQ-025 out_data/out_valid stable while out_valid && !out_ready.
REQ-026 Read/write pointers wrap modulo DEPTH; order strictly FIFO.
REQ-027 count, almost_full reflect registered state (update one cycle after push/pop edge).
REQ-028 err_clr clears overflow and skew_err next cycle; same-cycle new error wins (flag stays set).
REQ-029 Data passed bit-exact; no arithmetic, saturation or sign handling.

Reset
REQ-030 rst_n low asynchronously clears delay lines (valids 0), pointers, count=0, out_valid=0, almost_full=0, overflow=0, skew_err=0, out_data=0.
REQ-031 Reset mid-row discards partially aligned rows; no write of partial data after release.
REQ-032 First valid sample accepted on first rising edge after rst_n release.

Verification
REQ-033 N=4: rows 1..3 skewed back-to-back (column j value 16*r+j), out_ready=1 -> out_data rows {16r..16r+3} in order, first out_valid 4 cycles after row-1 column-0 valid.
REQ-034 out_ready=0, 8 rows pushed -> count=8, almost_full high at count>=4, 9th row sets overflow, 8 stored rows read intact.
REQ-035 Full FIFO, out_ready=1 with simultaneous aligned write -> count stays 8, overflow stays 0.
REQ-036 Column 2 valid suppressed for one row -> skew_err=1, row absent from output, next row correct; err_clr -> skew_err=0.
REQ-037 rst_n pulsed low after column 1 of a row enters -> after release out_valid=0, count=0, no row emitted for that partial row.
REQ-038 Random skewed traffic vs random out_ready, 10k cycles -> output matches reference queue, overflow only when model full.
